split_unit: RTL and testbench
=============================

Name: split_unit

Overview:
- Inverse of the packed-lane concatenation in the special-functions path.
- Accepts one packed word of NUM_ELEMS lanes and emits the lanes serially, one ELEM_WIDTH element per transfer, most-significant lane first.
- Sits between a packed producer (concat output, wide SRAM read) and element-wise consumers.
- valid/ready handshake on both sides; sustains one element per cycle with back-to-back words.

Parameters:
ELEM_WIDTH, 16, bits per element
NUM_ELEMS, 2, lanes per packed word (legal 1..16)
IDX_W, derived = max(1, clog2(NUM_ELEMS)), width of elem_idx

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous and active-high
data_in  input  ELEM_WIDTH*NUM_ELEMS  packed word; lane 0 = MS slice [W*N-1 -: W]
valid_in  input  1  data_in valid
ready_in  output  1  unit can accept data_in this cycle
data_out  output  ELEM_WIDTH  current element
elem_idx  output  IDX_W  lane index of data_out (0 = MS lane)
last_out  output  1  data_out is the final lane of its word
valid_out  output  1  data_out/elem_idx/last_out valid
ready_out  input  1  consumer accepts element this cycle

Behaviour:
- Reset (rst=1 at clk edge) clears:
  - valid_out=0, data_out=0, elem_idx=0, last_out=0.
  - Holding register=0; state=IDLE.
  - ready_in is forced to 0 while rst=1.
- Mid-word reset discards all remaining lanes. No element is emitted after reset until a new word is accepted.
- Internal:
  - hold_reg [W*N-1:0] stores the word.
  - cnt [IDX_W-1:0] holds the current lane.
  - Two states: IDLE (empty) and EMIT (hold_reg valid).
- Accept: in_fire = valid_in && ready_in. Out_fire = valid_out && ready_out.
- ready_in (combinational) = !rst && (state==IDLE || (out_fire && last_out)). No combinational path from valid_in to ready_in.
- IDLE:
  - On in_fire, latch data_in into hold_reg, set cnt=0, state=EMIT.
  - In the same edge, register data_out = lane 0, elem_idx=0, valid_out=1, last_out=(NUM_ELEMS==1).
  - Latency: word accepted at edge k, lane 0 visible from edge k (valid in cycle k+1).
- EMIT, no out_fire:
  - All outputs hold stable.
  - data_out, elem_idx and last_out must not change while valid_out && !ready_out.
- EMIT, out_fire with last_out=0:
  - cnt increments.
  - data_out = lane cnt+1; elem_idx=cnt+1.
  - last_out = (cnt+1 == NUM_ELEMS-1).
  - valid_out stays 1.
- EMIT, out_fire with last_out=1:
  - If in_fire is also true, load the new word and present its lane 0 next cycle. valid_out stays 1 with no bubble.
  - Otherwise valid_out=0, last_out=0, state=IDLE. data_out holds its last value.
- Lane slicing: lane i = hold_reg[W*(N-i)-1 -: W]. No arithmetic; bits pass unmodified.
- Throughput: steady state is N output cycles per word. An input word is accepted only on the cycle its predecessor's last lane fires.
- NUM_ELEMS=1: every element has last_out=1. Behaves as a one-deep registered pipe stage with full throughput.
- valid_in while ready_in=0: ignored. The producer holds data_in per protocol; the unit does not latch it.
- elem_idx wraps to 0 only by loading a new word. cnt never exceeds NUM_ELEMS-1.

Test Plan:
- Reset then idle:
  - Assert rst 3 cycles with valid_in=1.
  - Expect ready_in=0 and valid_out=0 throughout.
  - Deassert; expect ready_in=1 the next cycle and all outputs at 0.
- Single word (N=2, W=16), ready_out=1:
  - data_in=0xAAAA5555 accepted at edge k.
  - Cycle k+1: data_out=0xAAAA, idx=0, last=0.
  - Cycle k+2: data_out=0x5555, idx=1, last=1.
  - Cycle k+3: valid_out=0.
- Back-to-back:
  - Words 0x11112222, 0x33334444, 0x55556666 with valid_in and ready_out held 1.
  - Output stream is 1111, 2222, 3333, 4444, 5555, 6666 on consecutive cycles with no bubble.
  - ready_in pulses high only on last-lane cycles.
- Backpressure:
  - Word 0xDEADBEEF; ready_out=0 for 4 cycles, then 1.
  - data_out stays 0xDEAD, idx=0 through the stall.
  - Then 0xBEEF with last=1; ready_in stays 0 until the last lane fires.
- Reset mid-word:
  - Accept 0xCAFEF00D, consume 0xCAFE, then assert rst for 1 cycle.
  - Expect valid_out=0 and no 0xF00D emitted.
  - A new word 0x12345678 then emits 0x1234 first.
- Parameter sweep:
  - N=4, W=8, word 0xA1B2C3D4 with random ready_out.
  - Expect A1, B2, C3, D4 with idx 0..3 and last only on D4.
  - N=1, W=16 sustains one word per cycle with last_out=1.

Source files
------------

// File: rtl/split_unit_if.sv
// Handshake bundle for split_unit: packed-word input side and element output side.
interface split_unit_if #(
  parameter int unsigned ELEM_WIDTH = 16,
  parameter int unsigned NUM_ELEMS  = 2
);
  localparam int unsigned IDX_W = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  logic [ELEM_WIDTH*NUM_ELEMS-1:0] data_in;
  logic                            valid_in;
  logic                            ready_in;
  logic [ELEM_WIDTH-1:0]           data_out;
  logic [IDX_W-1:0]                elem_idx;
  logic                            last_out;
  logic                            valid_out;
  logic                            ready_out;

  // Producer and consumer side, as seen from outside the unit.
  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, elem_idx, last_out, valid_out
  );

  // The split unit itself.
  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, elem_idx, last_out, valid_out
  );
endinterface

// File: rtl/split_unit.sv
// split_unit: serialises a packed word of NUM_ELEMS lanes, most-significant lane first,
// one ELEM_WIDTH element per transfer. The next word is accepted on the cycle the
// previous word's last lane fires, so back-to-back words stream without bubbles.
module split_unit #(
  parameter int unsigned ELEM_WIDTH = 16,
  parameter int unsigned NUM_ELEMS  = 2
) (
  input logic         clk,
  input logic         rst,
  split_unit_if.slave bus
);
  localparam int unsigned IDX_W  = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam int unsigned WORD_W = ELEM_WIDTH * NUM_ELEMS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [WORD_W-1:0]     hold_q, hold_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [ELEM_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic                  valid_q, valid_d;
  logic                  in_fire, out_fire, ready_in_w;

  // ready_in depends only on state and the consumer side, never on valid_in.
  assign out_fire   = valid_q && bus.ready_out;
  assign ready_in_w = !rst && ((state_q == StIdle) || (out_fire && last_q));
  assign in_fire    = bus.valid_in && ready_in_w;
  assign cnt_inc    = cnt_q + IDX_W'(1);

  // Next-state: load a new word, advance to the next lane, or go idle.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (in_fire) begin
      // Lane 0 is taken straight from the input so it is visible one cycle after accept.
      state_d = StEmit;
      hold_d  = bus.data_in;
      cnt_d   = '0;
      data_d  = bus.data_in[WORD_W-1 -: ELEM_WIDTH];
      last_d  = (NUM_ELEMS == 1);
      valid_d = 1'b1;
    end else if (state_q == StEmit && out_fire) begin
      if (last_q) begin
        // data_out deliberately keeps its last value.
        state_d = StIdle;
        last_d  = 1'b0;
        valid_d = 1'b0;
      end else begin
        cnt_d  = cnt_inc;
        data_d = hold_q[WORD_W - 1 - ELEM_WIDTH * int'(cnt_inc) -: ELEM_WIDTH];
        last_d = (cnt_inc == LAST_IDX);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hold_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.ready_in  = ready_in_w;
  assign bus.data_out  = data_q;
  assign bus.elem_idx  = cnt_q;
  assign bus.last_out  = last_q;
  assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_split_unit.sv
// Bench for split_unit: three instances (N=2/W=16, N=4/W=8, N=1/W=16) driven from
// word queues; accepted words are expanded into expected lanes by a reference model
// and popped by per-instance monitors whenever an element transfers.
module tb_split_unit;
  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
  } elem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  split_unit_if #(.ELEM_WIDTH(16), .NUM_ELEMS(2)) ba ();
  split_unit_if #(.ELEM_WIDTH(8),  .NUM_ELEMS(4)) bb ();
  split_unit_if #(.ELEM_WIDTH(16), .NUM_ELEMS(1)) bc ();

  split_unit #(.ELEM_WIDTH(16), .NUM_ELEMS(2)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  split_unit #(.ELEM_WIDTH(8),  .NUM_ELEMS(4)) dut_b (.clk(clk), .rst(rst), .bus(bb));
  split_unit #(.ELEM_WIDTH(16), .NUM_ELEMS(1)) dut_c (.clk(clk), .rst(rst), .bus(bc));

  int n_checks = 0;
  int n_fail   = 0;

  elem_t       exp_a[$], exp_b[$], exp_c[$];
  logic [31:0] src_a[$], src_b[$], src_c[$];
  bit          acc_a, acc_b, acc_c;
  bit          gaps = 1'b0;
  bit          rnd_c = 1'b0;
  bit          rnd_b = 1'b1;
  bit          rst_at_edge = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: lane i of an n-lane word is the i-th w-bit field from the top.
  function automatic void push_lanes(input int which, input int n, input int w,
                                     input logic [31:0] word);
    for (int i = 0; i < n; i++) begin
      elem_t e;
      e.data = (word >> (w * (n - 1 - i))) & ((32'd1 << w) - 32'd1);
      e.idx  = i;
      e.last = (i == n - 1);
      case (which)
        0:       exp_a.push_back(e);
        1:       exp_b.push_back(e);
        default: exp_c.push_back(e);
      endcase
    end
  endfunction

  always @(posedge clk) rst_at_edge <= rst;

  // Monitor A (N=2, W=16).
  logic [31:0] pd_a; int pi_a; bit pl_a; bit stall_a = 1'b0;
  always @(negedge clk) begin : mon_a
    elem_t e;
    if (rst) begin
      chk("a_rst_ready_in", 32'(ba.ready_in), 32'd0);
      if (rst_at_edge) chk("a_rst_valid_out", 32'(ba.valid_out), 32'd0);
      stall_a = 1'b0;
    end else begin
      chk("a_ready_in", 32'(ba.ready_in),
          32'(exp_a.size() == 0 || (exp_a.size() == 1 && ba.ready_out)));
      chk("a_valid_out", 32'(ba.valid_out), 32'(exp_a.size() != 0));
      if (stall_a) begin
        chk("a_stall_data", 32'(ba.data_out), pd_a);
        chk("a_stall_idx", 32'(ba.elem_idx), 32'(pi_a));
        chk("a_stall_last", 32'(ba.last_out), 32'(pl_a));
      end
      if (ba.valid_out && ba.ready_out && exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_data", 32'(ba.data_out), e.data);
        chk("a_idx", 32'(ba.elem_idx), 32'(e.idx));
        chk("a_last", 32'(ba.last_out), 32'(e.last));
      end
      stall_a = ba.valid_out && !ba.ready_out;
      pd_a = 32'(ba.data_out); pi_a = int'(ba.elem_idx); pl_a = ba.last_out;
    end
  end

  // Monitor B (N=4, W=8).
  logic [31:0] pd_b; int pi_b; bit pl_b; bit stall_b = 1'b0;
  always @(negedge clk) begin : mon_b
    elem_t e;
    if (rst) begin
      chk("b_rst_ready_in", 32'(bb.ready_in), 32'd0);
      if (rst_at_edge) chk("b_rst_valid_out", 32'(bb.valid_out), 32'd0);
      stall_b = 1'b0;
    end else begin
      chk("b_ready_in", 32'(bb.ready_in),
          32'(exp_b.size() == 0 || (exp_b.size() == 1 && bb.ready_out)));
      chk("b_valid_out", 32'(bb.valid_out), 32'(exp_b.size() != 0));
      if (stall_b) begin
        chk("b_stall_data", 32'(bb.data_out), pd_b);
        chk("b_stall_idx", 32'(bb.elem_idx), 32'(pi_b));
        chk("b_stall_last", 32'(bb.last_out), 32'(pl_b));
      end
      if (bb.valid_out && bb.ready_out && exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("b_data", 32'(bb.data_out), e.data);
        chk("b_idx", 32'(bb.elem_idx), 32'(e.idx));
        chk("b_last", 32'(bb.last_out), 32'(e.last));
      end
      stall_b = bb.valid_out && !bb.ready_out;
      pd_b = 32'(bb.data_out); pi_b = int'(bb.elem_idx); pl_b = bb.last_out;
    end
  end

  // Monitor C (N=1, W=16).
  always @(negedge clk) begin : mon_c
    elem_t e;
    if (rst) begin
      chk("c_rst_ready_in", 32'(bc.ready_in), 32'd0);
      if (rst_at_edge) chk("c_rst_valid_out", 32'(bc.valid_out), 32'd0);
    end else begin
      chk("c_ready_in", 32'(bc.ready_in),
          32'(exp_c.size() == 0 || (exp_c.size() == 1 && bc.ready_out)));
      chk("c_valid_out", 32'(bc.valid_out), 32'(exp_c.size() != 0));
      if (bc.valid_out && bc.ready_out && exp_c.size() != 0) begin
        e = exp_c.pop_front();
        chk("c_data", 32'(bc.data_out), e.data);
        chk("c_idx", 32'(bc.elem_idx), 32'(e.idx));
        chk("c_last", 32'(bc.last_out), 32'(e.last));
      end
    end
  end

  // One clock of stimulus: drive after the edge, record acceptances after the monitors.
  task automatic step(input bit rdy_a, input bit rst_v);
    @(posedge clk);
    #1;
    rst = rst_v;
    if (rst_v) begin
      exp_a.delete();
      exp_b.delete();
      exp_c.delete();
    end
    if (acc_a) begin ba.valid_in = 1'b0; acc_a = 1'b0; end
    if (acc_b) begin bb.valid_in = 1'b0; acc_b = 1'b0; end
    if (acc_c) begin bc.valid_in = 1'b0; acc_c = 1'b0; end
    ba.ready_out = rdy_a;
    bb.ready_out = rnd_b ? ($urandom_range(0, 2) != 0) : 1'b1;
    bc.ready_out = rnd_c ? ($urandom_range(0, 1) != 0) : 1'b1;
    if (!ba.valid_in) begin
      if (src_a.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        ba.valid_in = 1'b1;
        ba.data_in  = src_a[0];
      end else ba.data_in = $urandom;
    end
    if (!bb.valid_in) begin
      if (src_b.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        bb.valid_in = 1'b1;
        bb.data_in  = src_b[0];
      end else bb.data_in = $urandom;
    end
    if (!bc.valid_in) begin
      if (src_c.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
        bc.valid_in = 1'b1;
        bc.data_in  = src_c[0][15:0];
      end else bc.data_in = 16'($urandom);
    end
    @(negedge clk);
    #1;
    if (!rst) begin
      if (ba.valid_in && ba.ready_in) begin push_lanes(0, 2, 16, src_a.pop_front()); acc_a = 1; end
      if (bb.valid_in && bb.ready_in) begin push_lanes(1, 4, 8, src_b.pop_front()); acc_b = 1; end
      if (bc.valid_in && bc.ready_in) begin push_lanes(2, 1, 16, src_c.pop_front()); acc_c = 1; end
    end
  endtask

  function automatic bit busy(input bit all);
    busy = src_a.size() != 0 || exp_a.size() != 0;
    if (all) busy = busy || src_b.size() != 0 || exp_b.size() != 0 ||
                    src_c.size() != 0 || exp_c.size() != 0;
  endfunction

  task automatic drain(input bit all, input int budget);
    int n = 0;
    while (busy(all) && n < budget) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk("drain_in_budget", 32'(busy(all)), 32'd0);
  endtask

  initial begin
    ba.valid_in = 0; ba.data_in = '0; ba.ready_out = 0;
    bb.valid_in = 0; bb.data_in = '0; bb.ready_out = 0;
    bc.valid_in = 0; bc.data_in = '0; bc.ready_out = 0;

    // Reset held 3 cycles while words are already offered.
    src_a.push_back(32'hAAAA5555);
    src_b.push_back(32'hA1B2C3D4);
    for (int i = 0; i < 6; i++) src_c.push_back(32'($urandom_range(0, 65535)));
    repeat (3) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("post_rst_ready_in", 32'(ba.ready_in), 32'd1);
    chk("post_rst_data_out", 32'(ba.data_out), 32'd0);
    chk("post_rst_elem_idx", 32'(ba.elem_idx), 32'd0);
    chk("post_rst_last_out", 32'(ba.last_out), 32'd0);
    drain(1'b0, 20);

    // Back-to-back words with valid_in and ready_out held high.
    src_a.push_back(32'h11112222);
    src_a.push_back(32'h33334444);
    src_a.push_back(32'h55556666);
    drain(1'b0, 30);

    // Backpressure: stall 4 cycles on the first lane.
    src_a.push_back(32'hDEADBEEF);
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    drain(1'b0, 20);

    // Reset after the first lane of a word has been consumed.
    src_a.push_back(32'hCAFEF00D);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    src_a.push_back(32'h12345678);
    drain(1'b0, 20);

    // Randomised traffic on all instances with input gaps and random backpressure.
    gaps  = 1'b1;
    rnd_c = 1'b1;
    for (int i = 0; i < 150; i++) begin
      src_a.push_back($urandom);
      src_b.push_back($urandom);
      src_c.push_back(32'($urandom_range(0, 65535)));
    end
    for (int i = 0; i < 3000 && busy(1'b1); i++) step($urandom_range(0, 3) != 0, 1'b0);

    // Full-throughput pass on the N=1 instance, then drain everything.
    gaps  = 1'b0;
    rnd_c = 1'b0;
    rnd_b = 1'b0;
    for (int i = 0; i < 20; i++) src_c.push_back(32'($urandom_range(0, 65535)));
    drain(1'b1, 3000);
    repeat (3) step(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end
endmodule
